// File: rtl/decoder_pipe_pkg.sv
// Shared types and the decode helper for decoder_pipe.
package decoder_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned DEC_MAX_W = 256;

  typedef logic [DEC_MAX_W:0] dec_vec_t;

  // Returns the word in bits [out_w-1:0] and err in bit out_w, so callers
  // truncate the result to out_w+1 bits to get {err, word}.
  function automatic dec_vec_t dec_word(input logic [31:0] code, input int unsigned out_w,
                                        input logic en, input logic thermo);
    dec_vec_t res;
    res = '0;
    if (en) begin
      if (code >= out_w) begin
        for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
          res[i] = thermo && (i < out_w);
        end
        res[out_w] = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
          res[i] = thermo ? (i <= code) : (i == code);
        end
      end
    end else begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready/out_valid.
module dec_skid_buf
  import decoder_pipe_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_r, state_nxt_s;
  logic [WIDTH-1:0] or_r, sk_r;
  logic             in_ready_r, out_valid_r;
  logic             accept_s, xfer_s;
  logic             load_or_s, load_sk_s, or_from_sk_s;

  assign accept_s  = in_valid && in_ready_r;
  assign xfer_s    = out_valid_r && out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = or_r;

  // Next-state and register-load selection.
  always_comb begin
    state_nxt_s  = state_r;
    load_or_s    = 1'b0;
    load_sk_s    = 1'b0;
    or_from_sk_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          load_or_s   = 1'b1;
          state_nxt_s = ONE;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && xfer_s) begin
          load_or_s   = 1'b1;
          state_nxt_s = ONE;
        end else if (accept_s) begin
          load_sk_s   = 1'b1;
          state_nxt_s = FULL;
        end else if (xfer_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      FULL: begin
        if (xfer_s) begin
          or_from_sk_s = 1'b1;
          state_nxt_s  = ONE;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State and handshake registers; flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  // Output and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_r <= '0;
      sk_r <= '0;
    end else begin
      if (load_or_s) begin
        or_r <= in_data;
      end else if (or_from_sk_s) begin
        or_r <= sk_r;
      end
      if (load_sk_s) begin
        sk_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined binary-to-one-hot decoder with valid/ready on both sides.
// Define DECODER_PIPE_THERMO_EN to add the thermo_mode input (thermometer decode).
module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  binary_in,
  input  logic             enable,
`ifdef DECODER_PIPE_THERMO_EN
  input  logic             thermo_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] decoder_out,
  output logic             range_err
);

  logic             thermo_s;
  logic [OUT_W:0]   din_s;
  logic [OUT_W:0]   dout_s;

`ifdef DECODER_PIPE_THERMO_EN
  assign thermo_s = thermo_mode;
`else
  assign thermo_s = 1'b0;
`endif

  // Decode on the input side; the buffer stores {range_err, word}.
  assign din_s = (OUT_W+1)'(dec_word(32'(binary_in), OUT_W, enable, thermo_s));

  dec_skid_buf #(
    .WIDTH(OUT_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (din_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (dout_s)
  );

  assign decoder_out = dout_s[OUT_W-1:0];
  assign range_err   = dout_s[OUT_W];

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe: directed plan items plus random traffic vs a queue model.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  binary_in = 4'd0;
  logic        enable = 1'b0;
  logic        thermo = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready16, out_valid16, range_err16;
  logic [15:0] decoder_out16;
  logic        in_ready10, out_valid10, range_err10;
  logic [9:0]  decoder_out10;

  int tests = 0;
  int fails = 0;
  logic [16:0] q16[$];
  logic [16:0] q10[$];

  always #5 clk = ~clk;

  decoder_pipe #(.IN_W(4), .OUT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .binary_in(binary_in), .enable(enable),
`ifdef DECODER_PIPE_THERMO_EN
    .thermo_mode(thermo),
`endif
    .out_valid(out_valid16), .out_ready(out_ready),
    .decoder_out(decoder_out16), .range_err(range_err16)
  );

  decoder_pipe #(.IN_W(4), .OUT_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready10),
    .binary_in(binary_in), .enable(enable),
`ifdef DECODER_PIPE_THERMO_EN
    .thermo_mode(thermo),
`endif
    .out_valid(out_valid10), .out_ready(out_ready),
    .decoder_out(decoder_out10), .range_err(range_err10)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode: {err, word} from the plain arithmetic rules.
  function automatic logic [16:0] exp_val(input int code, input bit en, input bit th, input int outw);
    longint w;
    bit e;
    if (!en) begin
      w = 0; e = 1'b0;
    end else if (code >= outw) begin
      e = 1'b1;
      w = th ? ((64'd1 << outw) - 1) : 0;
    end else begin
      e = 1'b0;
      w = th ? ((64'd2 << code) - 1) : (64'd1 << code);
    end
    return {e, w[15:0]};
  endfunction

  task automatic check_model();
    check_eq("ov16", 32'(out_valid16), 32'(q16.size() > 0));
    check_eq("ir16", 32'(in_ready16), 32'(q16.size() < 2));
    check_eq("ov10", 32'(out_valid10), 32'(q10.size() > 0));
    check_eq("ir10", 32'(in_ready10), 32'(q10.size() < 2));
    if (q16.size() > 0) check_eq("data16", 32'({range_err16, decoder_out16}), 32'(q16[0]));
    if (q10.size() > 0) check_eq("data10", 32'({range_err10, 6'd0, decoder_out10}), 32'(q10[0]));
  endtask

  // One clock: check state at negedge, drive inputs, update model at posedge.
  task automatic cyc(input bit iv, input logic [3:0] code, input bit en, input bit th,
                     input bit ordy, output bit acc);
    bit xfr;
    bit th_eff;
`ifdef DECODER_PIPE_THERMO_EN
    th_eff = th;
`else
    th_eff = 1'b0;
`endif
    @(negedge clk);
    check_model();
    in_valid = iv; binary_in = code; enable = en; thermo = th_eff; out_ready = ordy;
    acc = iv && (q16.size() < 2);
    xfr = (q16.size() > 0) && ordy;
    @(posedge clk);
    if (xfr) begin
      void'(q16.pop_front());
      void'(q10.pop_front());
    end
    if (acc) begin
      q16.push_back(exp_val(int'(code), en, th_eff, 16));
      q10.push_back(exp_val(int'(code), en, th_eff, 10));
    end
  endtask

  initial begin
    bit acc;
    bit hv;
    bit he;
    bit ht;
    logic [3:0] hc;

    #7;
    check_eq("rst_ov", 32'(out_valid16), 32'd0);
    check_eq("rst_ir", 32'(in_ready16), 32'd1);
    check_eq("rst_out", 32'(decoder_out16), 32'd0);
    check_eq("rst_err", 32'(range_err16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 4'(i), 1'b1, 1'b0, 1'b1, acc);
      #1;
      check_eq("stream_out", 32'(decoder_out16), 32'd1 << i);
      check_eq("stream_ir", 32'(in_ready16), 32'd1);
    end

    cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, acc);
    #1;
    check_eq("en0_out", 32'(decoder_out16), 32'h0000);
    check_eq("en0_err", 32'(range_err16), 32'd0);
    check_eq("en0_ov", 32'(out_valid16), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);

    cyc(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, acc);
    #1;
    check_eq("bp_ir", 32'(in_ready16), 32'd0);
    check_eq("bp_hold", 32'(decoder_out16), 32'h0008);
    cyc(1'b1, 4'h4, 1'b1, 1'b0, 1'b1, acc);
    check_eq("bp_noacc", 32'(acc), 32'd0);
    #1;
    check_eq("bp_second", 32'(decoder_out16), 32'h0200);
    check_eq("bp_ir_back", 32'(in_ready16), 32'd1);
    cyc(1'b1, 4'h4, 1'b1, 1'b0, 1'b1, acc);
    check_eq("bp_acc", 32'(acc), 32'd1);
    cyc(1'b0, 4'h4, 1'b1, 1'b0, 1'b1, acc);
    #1;
    check_eq("bp_third", 32'(decoder_out16), 32'h0010);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);

    cyc(1'b1, 4'hC, 1'b1, 1'b0, 1'b1, acc);
    #1;
    check_eq("rng_out", 32'(decoder_out10), 32'h000);
    check_eq("rng_err", 32'(range_err10), 32'd1);
    check_eq("rng_err16", 32'(range_err16), 32'd0);
    cyc(1'b1, 4'h9, 1'b1, 1'b0, 1'b1, acc);
    #1;
    check_eq("rng_top", 32'(decoder_out10), 32'h200);
    check_eq("rng_top_err", 32'(range_err10), 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);

`ifdef DECODER_PIPE_THERMO_EN
    cyc(1'b1, 4'h3, 1'b1, 1'b1, 1'b1, acc);
    #1;
    check_eq("th_3", 32'(decoder_out16), 32'h000F);
    cyc(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, acc);
    #1;
    check_eq("th_f", 32'(decoder_out16), 32'hFFFF);
    cyc(1'b1, 4'h3, 1'b1, 1'b0, 1'b1, acc);
    #1;
    check_eq("th_off", 32'(decoder_out16), 32'h0008);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
`endif

    cyc(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, acc);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ov", 32'(out_valid16), 32'd0);
    check_eq("arst_ir", 32'(in_ready16), 32'd1);
    check_eq("arst_ov10", 32'(out_valid10), 32'd0);
    q16.delete();
    q10.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);

    hv = 1'b0; he = 1'b0; ht = 1'b0; hc = 4'd0;
    for (int n = 0; n < 600; n++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        hc = 4'($urandom);
        he = ($urandom_range(0, 7) != 0);
        ht = $urandom_range(0, 1) == 1;
      end
      cyc(hv, hc, he, ht, $urandom_range(0, 3) != 0, acc);
      if (acc) hv = 1'b0;
    end
    for (int n = 0; n < 4; n++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised binary-to-one-hot decoder, generalised to IN_W → OUT_W.
- Registered output with valid/ready handshake on both sides, so the decoder can sit between pipelined datapath stages without breaking timing.
- Internal 2-entry skid buffer sustains one decode per clock.
- The enable input gates the result to all-zeros.

Parameters:
- IN_W, 4, width of binary code input.
- OUT_W, 16, width of decoded output; must satisfy 1 ≤ OUT_W ≤ 2**IN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- binary_in  input  IN_W  code to decode.
- enable  input  1  sampled with binary_in; 0 forces all-zero result.
- out_valid  output  1  decoded word valid.
- out_ready  input  1  downstream accepts decoded word.
- decoder_out  output  OUT_W  decoded word.
- range_err  output  1  qualifies decoder_out: code ≥ OUT_W while enabled.

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, decoder_out=0, range_err=0, state=EMPTY.
- Input accept: when in_valid && in_ready. Output transfer: when out_valid && out_ready.
- Decode function, computed at accept time:
  - enable=0: word=0, err=0.
  - enable=1 and binary_in < OUT_W: word=1<<binary_in, err=0.
  - enable=1 and binary_in ≥ OUT_W: word=0, err=1.
- Latency: an accepted word appears on decoder_out/range_err the next cycle with out_valid=1.
- The word is held stable while out_valid && !out_ready; no change until transfer.
- State machine (output reg OR, skid reg SK):
  - EMPTY: accept → OR, go ONE.
  - ONE, transfer only: → EMPTY.
  - ONE, accept only: → SK, go FULL.
  - ONE, accept and transfer together: new word → OR, stay ONE.
  - FULL, transfer: SK → OR, go ONE. No accept is possible in FULL.
- in_ready is a register: 1 in EMPTY/ONE, 0 in FULL. No combinational path from out_ready to in_ready.
- Throughput: 1 word/cycle with out_ready held high. Never drops or duplicates a word.
- in_valid while in_ready=0 is ignored; the source must hold the word.
- Reset mid-operation discards OR and SK contents immediately.
- OUT_W < 2**IN_W: upper codes take the range_err path.
- OUT_W == 2**IN_W: range_err is constant 0.

Optional Feature:
- Macro: DECODER_PIPE_THERMO_EN.
- Defined:
  - Adds input port thermo_mode (1 bit), sampled with binary_in.
  - thermo_mode=1 and enabled, in range: word = (2 << binary_in) - 1, i.e. bits 0..binary_in set.
  - Out of range: all-ones word, range_err=1.
  - thermo_mode=0: one-hot as above.
- Undefined: port absent; one-hot only; logic identical to the base behaviour.

Decomposition:
- Package decoder_pipe_pkg holds:
  - enum skid_state_t {EMPTY, ONE, FULL} (2-bit encoding);
  - parametrised function dec_word(code, en, thermo) returning word and err.
- Sub-module dec_skid_buf: generic WIDTH-bit 2-entry valid/ready skid buffer holding {range_err, word}.
  - Instantiated once with WIDTH=OUT_W+1.
  - Decode is done combinationally on the input side before the buffer.

Test Plan:
- Reset/basic: default params, out_ready=1; stream codes 0..15 with enable=1 → decoder_out 16'h0001..16'h8000 on consecutive cycles, latency 1, in_ready stays 1.
- Enable gating: binary_in=4'h5 with enable=0 → decoder_out=16'h0000, range_err=0, out_valid=1.
- Backpressure: out_ready=0, send 4'h3 then 4'h9.
  - Cycle 2: in_ready=0, out holds 16'h0008.
  - Then out_ready=1: 16'h0008 then 16'h0200, in_ready returns to 1.
  - Third word held on input during stall is accepted exactly once.
- Range error: IN_W=4, OUT_W=10, code 4'hC enabled → decoder_out=10'h000, range_err=1; code 4'h9 → 10'h200, range_err=0.
- Async reset mid-stall: state FULL, assert rst_n=0 between clock edges → out_valid=0 and in_ready=1 immediately; no stale word after release.
- Thermo (DECODER_PIPE_THERMO_EN): thermo_mode=1, code 4'h3 → 16'h000F; code 4'hF → 16'hFFFF; thermo_mode=0, code 4'h3 → 16'h0008.
